// File: rtl/rv32i_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the rv32i core.
// It decodes OP-IMM and OP only. Anything else, or a stalled fetch, halts in a sticky trap.
module rv32i_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic [2:0]  alu_control_o,
    output logic        alu_alt_o,
    output logic        alu_src_imm_o,
    output logic        reg_write_o,
    output logic [31:0] instret_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_TRAP
    } state_e;

    localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP      = 7'b0110011;
    localparam logic [6:0]  F7_ZERO     = 7'b0000000;
    localparam logic [6:0]  F7_ALT      = 7'b0100000;
    localparam logic [7:0]  WAIT_LAST   = 8'(MAX_WAIT - 1);
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_ILL   = 2'b01;
    localparam logic [1:0]  CAUSE_FETCH = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic [7:0]  wait_q, wait_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] imm_q, imm_d;
    logic [2:0]  alu_control_q, alu_control_d;
    logic        alu_alt_q, alu_alt_d;
    logic        alu_src_imm_q, alu_src_imm_d;
    logic [1:0]  trap_cause_q, trap_cause_d;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        legal;
    logic        alt_dec;
    logic        fetch_timeout;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    // ir[30] only selects sub/sra where that encoding exists; elsewhere it is immediate/shamt data.
    always_comb begin
        legal   = 1'b0;
        alt_dec = 1'b0;
        if (opcode == OPC_OP_IMM) begin
            case (funct3)
                3'b001:  legal = (funct7 == F7_ZERO);
                3'b101: begin
                    legal   = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    alt_dec = ir_q[30];
                end
                default: legal = 1'b1;
            endcase
        end else if (opcode == OPC_OP) begin
            if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
                legal   = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                alt_dec = ir_q[30];
            end else begin
                legal   = (funct7 == F7_ZERO);
            end
        end
    end

    assign fetch_timeout = !imem_ready_i && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:     state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (fetch_timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE:    state_d = legal ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_TRAP;
        endcase
    end

    // Decoded fields are only loaded on a legal DECODE, so they hold through EXECUTE and any trap.
    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        instret_d     = instret_q;
        wait_d        = wait_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        alu_control_d = alu_control_q;
        alu_alt_d     = alu_alt_q;
        alu_src_imm_d = alu_src_imm_q;
        trap_cause_d  = trap_cause_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready_i) begin
                    ir_d   = imem_rdata_i;
                    wait_d = 8'd0;
                end else if (fetch_timeout) begin
                    trap_cause_d = CAUSE_FETCH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    rs1_d         = ir_q[19:15];
                    rs2_d         = ir_q[24:20];
                    rd_d          = ir_q[11:7];
                    imm_d         = {{20{ir_q[31]}}, ir_q[31:20]};
                    alu_control_d = funct3;
                    alu_alt_d     = alt_dec;
                    alu_src_imm_d = (opcode == OPC_OP_IMM);
                end else begin
                    trap_cause_d  = CAUSE_ILL;
                end
            end
            ST_WRITEBACK: begin
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            ir_q          <= NOP;
            instret_q     <= 32'd0;
            wait_q        <= 8'd0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rd_q          <= 5'd0;
            imm_q         <= 32'd0;
            alu_control_q <= 3'd0;
            alu_alt_q     <= 1'b0;
            alu_src_imm_q <= 1'b0;
            trap_cause_q  <= 2'b00;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            instret_q     <= instret_d;
            wait_q        <= wait_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            alu_control_q <= alu_control_d;
            alu_alt_q     <= alu_alt_d;
            alu_src_imm_q <= alu_src_imm_d;
            trap_cause_q  <= trap_cause_d;
        end
    end

    always_comb begin
        imem_req_o  = (state_q == ST_FETCH);
        reg_write_o = (state_q == ST_WRITEBACK) && (rd_q != 5'd0);
        trap_o      = (state_q == ST_TRAP);
    end

    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign ir_o          = ir_q;
    assign rs1_o         = rs1_q;
    assign rs2_o         = rs2_q;
    assign rd_o          = rd_q;
    assign imm_o         = imm_q;
    assign alu_control_o = alu_control_q;
    assign alu_alt_o     = alu_alt_q;
    assign alu_src_imm_o = alu_src_imm_q;
    assign instret_o     = instret_q;
    assign trap_cause_o  = trap_cause_q;

endmodule

// File: tb/tb_rv32i_sequencer.sv
// Directed bench for rv32i_sequencer: instruction flow, wait states, decode, traps, reset and pc wrap.
// A second instance starts at 0xFFFF_FFFC to reach the pc wrap quickly.
module tb_rv32i_sequencer;

    localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
    localparam logic [31:0] SUB_X3    = 32'h4020_81B3;
    localparam logic [31:0] SRAI_X1   = 32'h4030_D093;
    localparam logic [31:0] ADDI_NEG  = 32'hC000_0093;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] JAL       = 32'h0000_006F;
    localparam logic [31:0] SLLI_BAD  = 32'h4000_9093;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic imemReady = 1'b1;
    logic [31:0] imemRdata = 32'h0000_0013;
    logic imemReq, aluAlt, aluSrcImm, regWrite, trap;
    logic [31:0] imemAddr, pc, ir, imm, instret;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] aluControl;
    logic [1:0] trapCause;

    logic wRst_n = 1'b1;
    logic wReady = 1'b1;
    logic [31:0] wRdata = 32'h0050_0093;
    logic wReq, wAluAlt, wAluSrcImm, wRegWrite, wTrap;
    logic [31:0] wAddr, wPc, wIr, wImm, wInstret;
    logic [4:0] wRs1, wRs2, wRd;
    logic [2:0] wAluControl;
    logic [1:0] wTrapCause;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    rv32i_sequencer #(.RESET_PC(32'h0000_0100), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imemReq), .imem_addr_o(imemAddr),
        .imem_ready_i(imemReady), .imem_rdata_i(imemRdata),
        .pc_o(pc), .ir_o(ir), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .imm_o(imm),
        .alu_control_o(aluControl), .alu_alt_o(aluAlt), .alu_src_imm_o(aluSrcImm),
        .reg_write_o(regWrite), .instret_o(instret), .trap_o(trap), .trap_cause_o(trapCause)
    );

    rv32i_sequencer #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) u_wrap (
        .clk(clk), .rst_n(wRst_n),
        .imem_req_o(wReq), .imem_addr_o(wAddr),
        .imem_ready_i(wReady), .imem_rdata_i(wRdata),
        .pc_o(wPc), .ir_o(wIr), .rs1_o(wRs1), .rs2_o(wRs2), .rd_o(wRd), .imm_o(wImm),
        .alu_control_o(wAluControl), .alu_alt_o(wAluAlt), .alu_src_imm_o(wAluSrcImm),
        .reg_write_o(wRegWrite), .instret_o(wInstret), .trap_o(wTrap), .trap_cause_o(wTrapCause)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imemReady = 1'b1;
        imemRdata = NOP;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imemReady = 1'b1;
        imemRdata = ADDI_X1_5;
        step();
        step();
        nCompared++; if (pc !== 32'h100) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h100); end
        nCompared++; if (ir !== NOP) begin nMismatched++; $display("[TB] FAIL reset_ir: got %h want %h", ir, NOP); end
        nCompared++; if ({rs1, rs2, rd, imm} !== 47'd0) begin nMismatched++; $display("[TB] FAIL reset_fields: got %h/%h/%h/%h want 0", rs1, rs2, rd, imm); end
        nCompared++; if ({aluControl, aluAlt, aluSrcImm} !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_alu: got %b/%b/%b want 0", aluControl, aluAlt, aluSrcImm); end
        nCompared++; if ({imemReq, regWrite, trap, trapCause} !== 5'd0 || instret !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_ctrl: req %b wr %b trap %b cause %b instret %h want all 0", imemReq, regWrite, trap, trapCause, instret); end
        rst_n = 1'b1;
        nCompared++; if (imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL req_at_release: got %b want 0", imemReq); end
        step();
        nCompared++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin nMismatched++; $display("[TB] FAIL first_req: req %b addr %h want 1 / 00000100", imemReq, imemAddr); end
    endtask

    task automatic test_addi_stream();
        step();
        nCompared++; if (ir !== ADDI_X1_5 || imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL addi_latch: ir %h req %b want %h / 0", ir, imemReq, ADDI_X1_5); end
        step();
        nCompared++; if (rd !== 5'd1 || imm !== 32'd5 || aluControl !== 3'd0 || aluSrcImm !== 1'b1 || rs1 !== 5'd0) begin
            nMismatched++; $display("[TB] FAIL addi_decode: rd %0d imm %h ctl %0d srcimm %b rs1 %0d want 1/5/0/1/0", rd, imm, aluControl, aluSrcImm, rs1); end
        nCompared++; if (regWrite !== 1'b0) begin nMismatched++; $display("[TB] FAIL addi_exec_wr: got %b want 0", regWrite); end
        step();
        nCompared++; if (regWrite !== 1'b1 || pc !== 32'h100) begin nMismatched++; $display("[TB] FAIL addi_wb: wr %b pc %h want 1 / 00000100", regWrite, pc); end
        step();
        nCompared++; if (pc !== 32'h104 || instret !== 32'd1 || regWrite !== 1'b0 || imemAddr !== 32'h104) begin
            nMismatched++; $display("[TB] FAIL addi_retire: pc %h instret %0d wr %b addr %h want 104/1/0/104", pc, instret, regWrite, imemAddr); end
        step();
        step();
        step();
        nCompared++; if (regWrite !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_second_pulse: got %b want 1", regWrite); end
        step();
        nCompared++; if (pc !== 32'h108 || instret !== 32'd2) begin nMismatched++; $display("[TB] FAIL addi_second_retire: pc %h instret %0d want 108/2", pc, instret); end
    endtask

    task automatic test_wait_states();
        imemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            nCompared++; if (imemReq !== 1'b1 || trap !== 1'b0) begin nMismatched++; $display("[TB] FAIL wait_hold_%0d: req %b trap %b want 1/0", i, imemReq, trap); end
        end
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        nCompared++; if (imemReq !== 1'b0 || ir !== ADDI_X1_5) begin nMismatched++; $display("[TB] FAIL wait_accept: req %b ir %h want 0/%h", imemReq, ir, ADDI_X1_5); end
        step();
        step();
        nCompared++; if (regWrite !== 1'b1) begin nMismatched++; $display("[TB] FAIL wait_wb: got %b want 1", regWrite); end
        imemReady = 1'b1;
        step();
        nCompared++; if (pc !== 32'h10C || instret !== 32'd3) begin nMismatched++; $display("[TB] FAIL wait_retire: pc %h instret %0d want 10c/3", pc, instret); end
    endtask

    task automatic run_to_execute(input logic [31:0] instr);
        imemRdata = instr;
        imemReady = 1'b1;
        step();
        step();
    endtask

    task automatic test_decode();
        run_to_execute(SUB_X3);
        nCompared++; if (aluAlt !== 1'b1 || aluSrcImm !== 1'b0 || rs2 !== 5'd2 || rs1 !== 5'd1 || rd !== 5'd3 || aluControl !== 3'd0) begin
            nMismatched++; $display("[TB] FAIL sub_decode: alt %b src %b rs2 %0d rs1 %0d rd %0d ctl %0d want 1/0/2/1/3/0", aluAlt, aluSrcImm, rs2, rs1, rd, aluControl); end
        step();
        step();
        run_to_execute(SRAI_X1);
        nCompared++; if (aluAlt !== 1'b1 || aluSrcImm !== 1'b1 || aluControl !== 3'd5 || imm !== 32'h403) begin
            nMismatched++; $display("[TB] FAIL srai_decode: alt %b src %b ctl %0d imm %h want 1/1/5/403", aluAlt, aluSrcImm, aluControl, imm); end
        step();
        step();
        run_to_execute(ADDI_NEG);
        nCompared++; if (aluAlt !== 1'b0 || imm !== 32'hFFFF_FC00) begin nMismatched++; $display("[TB] FAIL addi_neg_decode: alt %b imm %h want 0/fffffc00", aluAlt, imm); end
        step();
        step();
        run_to_execute(NOP);
        step();
        nCompared++; if (regWrite !== 1'b0) begin nMismatched++; $display("[TB] FAIL nop_no_write: got %b want 0", regWrite); end
        step();
        nCompared++; if (instret !== 32'd7 || pc !== 32'h11C) begin nMismatched++; $display("[TB] FAIL nop_retire: instret %0d pc %h want 7/11c", instret, pc); end
    endtask

    task automatic test_illegal(input logic [31:0] instr, input string tag);
        do_reset();
        step();
        run_to_execute(ADDI_X1_5);
        step();
        step();
        imemRdata = instr;
        step();
        step();
        nCompared++; if (trap !== 1'b1 || trapCause !== 2'b01 || regWrite !== 1'b0 || imemReq !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL %s_trap: trap %b cause %b wr %b req %b want 1/01/0/0", tag, trap, trapCause, regWrite, imemReq); end
        nCompared++; if (rd !== 5'd1 || imm !== 32'd5 || ir !== instr) begin nMismatched++; $display("[TB] FAIL %s_hold: rd %0d imm %h ir %h want 1/5/%h", tag, rd, imm, ir, instr); end
        for (int i = 0; i < 4; i++) begin
            imemReady = i[0];
            imemRdata = ADDI_X1_5;
            step();
        end
        nCompared++; if (pc !== 32'h104 || instret !== 32'd1 || trap !== 1'b1 || trapCause !== 2'b01 || imemReq !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL %s_sticky: pc %h instret %0d trap %b cause %b req %b want 104/1/1/01/0", tag, pc, instret, trap, trapCause, imemReq); end
    endtask

    task automatic test_timeout();
        do_reset();
        imemReady = 1'b0;
        step();
        for (int i = 1; i < 15; i++) begin
            step();
            nCompared++; if (trap !== 1'b0 || imemReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout_early_%0d: trap %b req %b want 0/1", i, trap, imemReq); end
        end
        step();
        nCompared++; if (trap !== 1'b1 || trapCause !== 2'b10 || imemReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL timeout_trap: trap %b cause %b req %b want 1/10/0", trap, trapCause, imemReq); end
        imemReady = 1'b1;
        step();
        step();
        nCompared++; if (pc !== 32'h100 || instret !== 32'd0 || trap !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout_frozen: pc %h instret %0d trap %b want 100/0/1", pc, instret, trap); end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        imemReady = 1'b0;
        step();
        for (int i = 1; i < 15; i++) step();
        imemReady = 1'b1;
        imemRdata = ADDI_X1_5;
        step();
        nCompared++; if (trap !== 1'b0 || imemReq !== 1'b0 || ir !== ADDI_X1_5) begin nMismatched++; $display("[TB] FAIL timeout_edge_accept: trap %b req %b ir %h want 0/0/%h", trap, imemReq, ir, ADDI_X1_5); end
        step();
        step();
        step();
        nCompared++; if (instret !== 32'd1 || pc !== 32'h104) begin nMismatched++; $display("[TB] FAIL timeout_edge_retire: instret %0d pc %h want 1/104", instret, pc); end
    endtask

    task automatic test_reset_mid();
        run_to_execute(SUB_X3);
        rst_n = 1'b0;
        #1;
        nCompared++; if (pc !== 32'h100 || instret !== 32'd0 || ir !== NOP || rd !== 5'd0 || rs2 !== 5'd0 || aluAlt !== 1'b0 || imemReq !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL reset_exec: pc %h instret %0d ir %h rd %0d rs2 %0d alt %b req %b want 100/0/13/0/0/0/0", pc, instret, ir, rd, rs2, aluAlt, imemReq); end
        step();
        rst_n = 1'b1;
        step();
        nCompared++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin nMismatched++; $display("[TB] FAIL restart: req %b addr %h want 1/100", imemReq, imemAddr); end
        run_to_execute(SUB_X3);
        step();
        nCompared++; if (regWrite !== 1'b1) begin nMismatched++; $display("[TB] FAIL wb_before_reset: got %b want 1", regWrite); end
        rst_n = 1'b0;
        #1;
        nCompared++; if (regWrite !== 1'b0 || pc !== 32'h100 || instret !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_wb: wr %b pc %h instret %0d want 0/100/0", regWrite, pc, instret); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        wRst_n = 1'b1;
        step();
        nCompared++; if (wPc !== 32'hFFFF_FFFC || wReq !== 1'b1) begin nMismatched++; $display("[TB] FAIL wrap_start: pc %h req %b want fffffffc/1", wPc, wReq); end
        step();
        step();
        step();
        nCompared++; if (wRegWrite !== 1'b1) begin nMismatched++; $display("[TB] FAIL wrap_wb: got %b want 1", wRegWrite); end
        step();
        nCompared++; if (wPc !== 32'd0 || wInstret !== 32'd1 || wAddr !== 32'd0) begin nMismatched++; $display("[TB] FAIL wrap_pc: pc %h instret %0d addr %h want 0/1/0", wPc, wInstret, wAddr); end
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        wRst_n = 1'b0;
        test_reset();
        test_addi_stream();
        test_wait_states();
        test_decode();
        test_illegal(JAL, "jal");
        test_illegal(SLLI_BAD, "slli_bad");
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
